load_monitor_mc: RTL and testbench

//   Multi-channel, parametrised successor of the single-rail load UV sensor. Monitors CHANNELS

---
 rtl/load_monitor_mc.sv | 192 +++++++++++++++++++
 tb/tb_load_monitor_mc.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/load_monitor_mc.sv
// load_monitor_mc: per-channel under-voltage / high-load monitor with hysteresis and debounce.
// Latency: a flag changes on the edge that captures the FILT_CYC-th qualifying sample; any_uv lags uv by one cycle.
// Backpressure: none; samples are consumed only on sample_vld cycles, and idle cycles hold all state.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   sample_vld               v_code/i_code valid for every channel this cycle
//   v_code, i_code           packed unsigned samples, channel k at [k*DATA_W +: DATA_W]
//   uv, hl                   registered per-channel filtered under-voltage / high-load flags
//   any_uv                   registered OR of uv
//   clr_fault, uv_lat, hl_lat  sticky fault record and its clear (LOAD_MON_STICKY_EN builds only)
//
// Build option: define LOAD_MON_STICKY_EN to add the sticky latches and clr_fault.

module load_monitor_mc #(
   parameter int CHANNELS = 4,
   parameter int DATA_W   = 10,
   parameter int UV_THR   = 500,
   parameter int UV_HYST  = 8,
   parameter int HL_THR   = 700,
   parameter int HL_HYST  = 8,
   parameter int FILT_CYC = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sample_vld,
   input  logic [CHANNELS*DATA_W-1:0]   v_code,
   input  logic [CHANNELS*DATA_W-1:0]   i_code,
   output logic [CHANNELS-1:0]          uv,
   output logic [CHANNELS-1:0]          hl,
   output logic                         any_uv
`ifdef LOAD_MON_STICKY_EN
   ,
   input  logic                         clr_fault,
   output logic [CHANNELS-1:0]          uv_lat,
   output logic [CHANNELS-1:0]          hl_lat
`endif
);

   localparam int CW = $clog2(FILT_CYC + 1);

   // Thresholds are compared in 32 bits so the release level never wraps.
   // A release level above the sample range simply never matches.
   localparam logic [31:0] UV_ASSERT_LVL  = 32'(UV_THR);
   localparam logic [31:0] UV_RELEASE_LVL = 32'(UV_THR + UV_HYST);
   localparam logic [31:0] HL_ASSERT_LVL  = 32'(HL_THR);
   // Release level clamps at 0; "i < 0" is then never true, so hl never releases.
   localparam logic [31:0] HL_RELEASE_LVL = (HL_THR > HL_HYST) ? 32'(HL_THR - HL_HYST) : 32'd0;
   localparam logic [CW:0] FILT_LIM       = (CW+1)'(FILT_CYC);

   typedef enum logic [1:0] {
      ST_OK           = 2'd0,
      ST_ASSERT_PEND  = 2'd1,
      ST_ACTIVE       = 2'd2,
      ST_RELEASE_PEND = 2'd3
   } state_e;

   typedef struct packed {
      state_e          st;
      logic [CW-1:0]   cnt;
   } fsm_t;

   // Shared debounce step for both the UV and HL machines.
   // Band samples (neither asrt nor rel) fall through as non-qualifying in PEND states.
   function automatic fsm_t fsm_next(input fsm_t cur, input logic asrt, input logic rel);
      fsm_t        nxt;
      logic [CW:0] inc;
      nxt = cur;
      inc = {1'b0, cur.cnt} + (CW+1)'(1);
      case (cur.st)
         ST_OK: begin
            if (asrt) begin
               if (FILT_CYC == 1) begin
                  nxt.st  = ST_ACTIVE;
                  nxt.cnt = '0;
               end else begin
                  nxt.st  = ST_ASSERT_PEND;
                  nxt.cnt = CW'(1);
               end
            end
         end
         ST_ASSERT_PEND: begin
            if (!asrt) begin
               nxt.st  = ST_OK;
               nxt.cnt = '0;
            end else if (inc >= FILT_LIM) begin
               nxt.st  = ST_ACTIVE;
               nxt.cnt = '0;
            end else begin
               nxt.cnt = inc[CW-1:0];
            end
         end
         ST_ACTIVE: begin
            if (rel) begin
               if (FILT_CYC == 1) begin
                  nxt.st  = ST_OK;
                  nxt.cnt = '0;
               end else begin
                  nxt.st  = ST_RELEASE_PEND;
                  nxt.cnt = CW'(1);
               end
            end
         end
         default: begin // ST_RELEASE_PEND
            if (!rel) begin
               nxt.st  = ST_ACTIVE;
               nxt.cnt = '0;
            end else if (inc >= FILT_LIM) begin
               nxt.st  = ST_OK;
               nxt.cnt = '0;
            end else begin
               nxt.cnt = inc[CW-1:0];
            end
         end
      endcase
      return nxt;
   endfunction

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [DATA_W-1:0] v_k, i_k;
      logic              uv_asrt, uv_rel, hl_asrt, hl_rel;
      fsm_t              uv_q, uv_d, hl_q, hl_d;
      logic              uv_flag_q, uv_flag_d, hl_flag_q, hl_flag_d;

      assign v_k     = v_code[k*DATA_W +: DATA_W];
      assign i_k     = i_code[k*DATA_W +: DATA_W];
      assign uv_asrt = 32'(v_k) <  UV_ASSERT_LVL;
      assign uv_rel  = 32'(v_k) >= UV_RELEASE_LVL;
      assign hl_asrt = 32'(i_k) >  HL_ASSERT_LVL;
      assign hl_rel  = 32'(i_k) <  HL_RELEASE_LVL;

      always_comb begin
         uv_d = uv_q;
         hl_d = hl_q;
         if (sample_vld) begin
            uv_d = fsm_next(uv_q, uv_asrt, uv_rel);
            hl_d = fsm_next(hl_q, hl_asrt, hl_rel);
         end
         // Flag is 1 in ACTIVE and while a release is still being debounced.
         uv_flag_d = (uv_d.st == ST_ACTIVE) || (uv_d.st == ST_RELEASE_PEND);
         hl_flag_d = (hl_d.st == ST_ACTIVE) || (hl_d.st == ST_RELEASE_PEND);
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            uv_q      <= '0;
            hl_q      <= '0;
            uv_flag_q <= 1'b0;
            hl_flag_q <= 1'b0;
         end else begin
            uv_q      <= uv_d;
            hl_q      <= hl_d;
            uv_flag_q <= uv_flag_d;
            hl_flag_q <= hl_flag_d;
         end
      end

      assign uv[k] = uv_flag_q;
      assign hl[k] = hl_flag_q;

`ifdef LOAD_MON_STICKY_EN
      logic uv_lat_q, hl_lat_q;

      // Latch on the rising edge of the flag only; a set on the clear cycle wins.
      always_ff @(posedge clk) begin
         if (rst) begin
            uv_lat_q <= 1'b0;
            hl_lat_q <= 1'b0;
         end else begin
            uv_lat_q <= (uv_flag_d & ~uv_flag_q) | (uv_lat_q & ~clr_fault);
            hl_lat_q <= (hl_flag_d & ~hl_flag_q) | (hl_lat_q & ~clr_fault);
         end
      end

      assign uv_lat[k] = uv_lat_q;
      assign hl_lat[k] = hl_lat_q;
`endif
   end

   logic any_uv_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         any_uv_q <= 1'b0;
      end else begin
         any_uv_q <= |uv;
      end
   end

   assign any_uv = any_uv_q;

endmodule

// File: tb/tb_load_monitor_mc.sv
module tb_load_monitor_mc;

   localparam int CH = 2;
   localparam int DW = 10;

   logic               clk = 1'b0;
   logic               rst;
   logic               sample_vld;
   logic [CH*DW-1:0]   v_code;
   logic [CH*DW-1:0]   i_code;
   logic [CH-1:0]      uv;
   logic [CH-1:0]      hl;
   logic               any_uv;
`ifdef LOAD_MON_STICKY_EN
   logic               clr_fault;
   logic [CH-1:0]      uv_lat;
   logic [CH-1:0]      hl_lat;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   load_monitor_mc #(
      .CHANNELS(CH),
      .DATA_W  (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sample_vld (sample_vld),
      .v_code     (v_code),
      .i_code     (i_code),
      .uv         (uv),
      .hl         (hl),
      .any_uv     (any_uv)
`ifdef LOAD_MON_STICKY_EN
      ,
      .clr_fault  (clr_fault),
      .uv_lat     (uv_lat),
      .hl_lat     (hl_lat)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one cycle of inputs, clock it in, then settle 1 time unit past the edge.
   task automatic step(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                       input logic [DW-1:0] i0, input logic [DW-1:0] i1, input logic vld);
      v_code     = {v1, v0};
      i_code     = {i1, i0};
      sample_vld = vld;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(10'd600, 10'd600, 10'd100, 10'd100, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
`ifdef LOAD_MON_STICKY_EN
      clr_fault = 1'b0;
`endif
      idle();
      idle();
      chk("reset_uv", 32'(uv), 32'h0);
      chk("reset_hl", 32'(hl), 32'h0);
      chk("reset_any_uv", 32'(any_uv), 32'h0);
      rst = 1'b0;

      // 1: three low-voltage samples on ch0
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t1_uv_after2", 32'(uv), 32'h0);
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t1_uv_after3", 32'(uv), 32'h1);
      chk("t1_any_uv_lag", 32'(any_uv), 32'h0);
      idle();
      chk("t1_any_uv", 32'(any_uv), 32'h1);
      chk("t1_uv1_clear", 32'(uv[1]), 32'h0);

      // 2: interrupted assert, then hysteresis release
      rst = 1'b1; idle(); rst = 1'b0;
      chk("t2_rst_uv", 32'(uv), 32'h0);
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      step(10'd600, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t2_interrupted", 32'(uv), 32'h0);
      for (int n = 0; n < 3; n++) step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t2_assert", 32'(uv), 32'h1);
      for (int n = 0; n < 5; n++) step(10'd505, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t2_band_hold", 32'(uv), 32'h1);
      step(10'd508, 10'd600, 10'd100, 10'd100, 1'b1);
      step(10'd508, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t2_release_pend", 32'(uv), 32'h1);
      step(10'd508, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t2_released", 32'(uv), 32'h0);

      // 3: high load on ch1 with idle gaps between valid samples
      step(10'd600, 10'd600, 10'd100, 10'd701, 1'b1);
      idle();
      idle();
      step(10'd600, 10'd600, 10'd100, 10'd701, 1'b1);
      idle();
      chk("t3_hl_after2", 32'(hl), 32'h0);
      step(10'd600, 10'd600, 10'd100, 10'd701, 1'b1);
      chk("t3_hl_after3", 32'(hl), 32'h2);
      chk("t3_uv_indep", 32'(uv), 32'h0);

      // 4: reset mid-filter discards the partial count; rst beats sample_vld
      rst = 1'b1; step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1); rst = 1'b0;
      chk("t4_rst_hl", 32'(hl), 32'h0);
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      rst = 1'b1; step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1); rst = 1'b0;
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t4_fresh1", 32'(uv), 32'h0);
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t4_fresh2", 32'(uv), 32'h0);
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t4_fresh3", 32'(uv), 32'h1);

      // 6: extreme codes on all channels, then reset
      rst = 1'b1; idle(); rst = 1'b0;
      for (int n = 0; n < 3; n++) step(10'd0, 10'd0, 10'd1023, 10'd1023, 1'b1);
      chk("t6_uv_all", 32'(uv), 32'h3);
      chk("t6_hl_all", 32'(hl), 32'h3);
      idle();
      chk("t6_any_uv", 32'(any_uv), 32'h1);
      rst = 1'b1; idle(); rst = 1'b0;
      chk("t6_rst_uv", 32'(uv), 32'h0);
      chk("t6_rst_hl", 32'(hl), 32'h0);
      chk("t6_rst_any_uv", 32'(any_uv), 32'h0);

`ifdef LOAD_MON_STICKY_EN
      // 5: sticky record, clear, and set-wins-over-clear
      chk("t5_lat_reset", 32'(uv_lat), 32'h0);
      for (int n = 0; n < 3; n++) step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t5_lat_set", 32'(uv_lat), 32'h1);
      for (int n = 0; n < 3; n++) step(10'd508, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t5_uv_released", 32'(uv), 32'h0);
      chk("t5_lat_held", 32'(uv_lat), 32'h1);
      clr_fault = 1'b1; idle(); clr_fault = 1'b0;
      chk("t5_lat_cleared", 32'(uv_lat), 32'h0);
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      clr_fault = 1'b1;
      step(10'd499, 10'd600, 10'd100, 10'd100, 1'b1);
      chk("t5_set_wins", 32'(uv_lat), 32'h1);
      idle();
      clr_fault = 1'b0;
      chk("t5_clr_while_uv", 32'(uv_lat), 32'h0);
      idle();
      chk("t5_no_reset_level", 32'(uv_lat), 32'h0);
      chk("t5_hl_lat", 32'(hl_lat), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
